// File: rtl/delay_timer_multi.sv
// delay_timer_multi: programmable delay followed by a programmable-width pulse.
// Modes: one-shot, retriggerable one-shot and periodic. An optional prescaler
// sets the length of a delay tick in clk cycles.
// Optional feature macro: DELAY_TIMER_OVERRUN_EN adds a sticky overrun flag
// (output overrun, input overrun_clr) that is set by triggers dropped while busy.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for trigger; all outputs low, counter at 0
// S_COUNT | delay counter running, decremented once per tick
// S_PULSE | pulse_out high; done marks the final pulse cycle
module delay_timer_multi #(
  parameter int CNT_W    = 16,
  parameter int PW_W     = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] delay_load,
  input  logic [PW_W-1:0]  pulse_len,
`ifdef DELAY_TIMER_OVERRUN_EN
  input  logic             overrun_clr,
  output logic             overrun,
`endif
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_value
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;

  localparam logic [1:0] M_ONESHOT = 2'd0;
  localparam logic [1:0] M_RETRIG  = 2'd1;
  localparam logic [1:0] M_PERIOD  = 2'd2;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [1:0]       state;
  logic [1:0]       cap_mode;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cap_delay;
  logic [PW_W-1:0]  cap_len;
  logic [PW_W-1:0]  pw_cnt;
  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [PW_W-1:0]  len_eff;
  logic [1:0]       mode_eff;

  // Tick strobe and normalised inputs; a zero pulse length behaves as one cycle
  // and the reserved mode code behaves as one-shot.
  always_comb begin
    tick     = (presc == PS_MAX);
    len_eff  = (pulse_len == '0) ? PW_W'(1) : pulse_len;
    mode_eff = (mode == 2'b11) ? M_ONESHOT : mode;
  end

  assign count_value = counter;

  // Main sequencer: trigger acceptance, delay countdown, pulse generation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cap_mode  <= M_ONESHOT;
      cap_delay <= '0;
      cap_len   <= PW_W'(1);
      counter   <= '0;
      pw_cnt    <= '0;
      presc     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        counter   <= '0;
        presc     <= '0;
        pulse_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (trigger) begin
              cap_delay <= delay_load;
              cap_len   <= len_eff;
              cap_mode  <= mode_eff;
              counter   <= delay_load;
              presc     <= '0;
              busy      <= 1'b1;
              state     <= S_COUNT;
            end
          end
          S_COUNT: begin
            // A retrigger restarts the whole delay, including the tick phase.
            if (trigger && cap_mode == M_RETRIG) begin
              counter <= delay_load;
              presc   <= '0;
            end else if (tick) begin
              presc <= '0;
              if (counter == '0) begin
                state     <= S_PULSE;
                pulse_out <= 1'b1;
                pw_cnt    <= cap_len;
                done      <= (cap_len == PW_W'(1));
              end else begin
                counter <= counter - CNT_W'(1);
              end
            end else begin
              presc <= presc + PS_W'(1);
            end
          end
          S_PULSE: begin
            if (pw_cnt == PW_W'(1)) begin
              pulse_out <= 1'b0;
              if (cap_mode == M_PERIOD) begin
                // Periodic restart: reload with no idle gap.
                state   <= S_COUNT;
                counter <= cap_delay;
                presc   <= '0;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              pw_cnt <= pw_cnt - PW_W'(1);
              done   <= (pw_cnt == PW_W'(2));
            end
          end
          default: begin
            state     <= S_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DELAY_TIMER_OVERRUN_EN
  logic trig_dropped;

  // A trigger is dropped whenever busy, except a retrigger during the delay.
  always_comb begin
    trig_dropped = trigger && (state != S_IDLE) &&
                   !(state == S_COUNT && cap_mode == M_RETRIG);
  end

  // Sticky overrun flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (trig_dropped) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_delay_timer_multi.sv
// Testbench for delay_timer_multi: two instances (PRESCALE=1 and PRESCALE=4)
// share one stimulus stream; a time-based reference model predicts outputs.
module tb_delay_timer_multi;
  localparam int CNT_W = 16;
  localparam int PW_W  = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             trigger = 1'b0;
  logic             abort = 1'b0;
  logic             overrun_clr = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W-1:0] delay_load = '0;
  logic [PW_W-1:0]  pulse_len = '0;

  logic             p1_po, p1_bz, p1_dn, p1_ov;
  logic             p4_po, p4_bz, p4_dn, p4_ov;
  logic [CNT_W-1:0] p1_cv, p4_cv;

  int tests = 0;
  int fails = 0;
  int dut_pc [2];
  int exp_pc [2];

  always #5 clk = ~clk;

  delay_timer_multi #(.CNT_W(CNT_W), .PW_W(PW_W), .PRESCALE(1)) dut_p1 (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .abort(abort),
    .mode(mode), .delay_load(delay_load), .pulse_len(pulse_len),
`ifdef DELAY_TIMER_OVERRUN_EN
    .overrun_clr(overrun_clr), .overrun(p1_ov),
`endif
    .pulse_out(p1_po), .busy(p1_bz), .done(p1_dn), .count_value(p1_cv));

  delay_timer_multi #(.CNT_W(CNT_W), .PW_W(PW_W), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .abort(abort),
    .mode(mode), .delay_load(delay_load), .pulse_len(pulse_len),
`ifdef DELAY_TIMER_OVERRUN_EN
    .overrun_clr(overrun_clr), .overrun(p4_ov),
`endif
    .pulse_out(p4_po), .busy(p4_bz), .done(p4_dn), .count_value(p4_cv));

`ifndef DELAY_TIMER_OVERRUN_EN
  assign p1_ov = 1'b0;
  assign p4_ov = 1'b0;
`endif

  typedef struct {
    logic             po;
    logic             bz;
    logic             dn;
    logic [CNT_W-1:0] cv;
    logic             ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: each activation is described by absolute edge times.
  longint cyc = 0;
  bit     m_busy [2];
  bit     m_ov [2];
  int     m_mode [2];
  int     m_d [2];
  int     m_l [2];
  longint load_c [2];
  longint start_c [2];
  longint end_c [2];
  int     ps [2] = '{1, 4};

  function automatic void set_times(int i);
    start_c[i] = load_c[i] + longint'(ps[i] * (m_d[i] + 1));
    end_c[i]   = start_c[i] + longint'(m_l[i]);
  endfunction

  task automatic model_step(int i);
    exp_t   e;
    bit     was_busy;
    bit     counting;
    longint el;
    e = '{po: 1'b0, bz: 1'b0, dn: 1'b0, cv: '0, ov: 1'b0};
    if (!reset_n) begin
      m_busy[i] = 1'b0;
      m_ov[i]   = 1'b0;
    end else begin
      was_busy = m_busy[i];
      counting = was_busy && (cyc - 1 < start_c[i]);
      if (was_busy && trigger && !(counting && m_mode[i] == 1)) m_ov[i] = 1'b1;
      else if (overrun_clr) m_ov[i] = 1'b0;
      if (abort) begin
        m_busy[i] = 1'b0;
      end else if (!was_busy) begin
        if (trigger) begin
          m_busy[i] = 1'b1;
          m_mode[i] = (mode == 2'd3) ? 0 : int'(mode);
          m_d[i]    = int'(delay_load);
          m_l[i]    = (pulse_len == 0) ? 1 : int'(pulse_len);
          load_c[i] = cyc;
          set_times(i);
        end
      end else if (counting && trigger && m_mode[i] == 1) begin
        m_d[i]    = int'(delay_load);
        load_c[i] = cyc;
        set_times(i);
      end else if (cyc == end_c[i]) begin
        if (m_mode[i] == 2) begin
          load_c[i] = cyc;
          set_times(i);
        end else begin
          m_busy[i] = 1'b0;
        end
      end
      if (m_busy[i]) begin
        e.bz = 1'b1;
        e.po = (cyc >= start_c[i]) && (cyc < end_c[i]);
        e.dn = (cyc == end_c[i] - 1);
        if (cyc < start_c[i]) begin
          el   = (cyc - load_c[i]) / ps[i];
          e.cv = (el >= m_d[i]) ? '0 : CNT_W'(longint'(m_d[i]) - el);
        end
      end
    end
    e.ov = m_ov[i];
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Model advances on every active edge and queues the expected outputs.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic chk(string nm, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pops queued expectations and compares away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("p1_pulse_out", p1_po, e.po);
      chk("p1_busy", p1_bz, e.bz);
      chk("p1_done", p1_dn, e.dn);
      chk("p1_count_value", p1_cv, e.cv);
`ifdef DELAY_TIMER_OVERRUN_EN
      chk("p1_overrun", p1_ov, e.ov);
`endif
      dut_pc[0] += int'(p1_po);
      exp_pc[0] += int'(e.po);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("p4_pulse_out", p4_po, e.po);
      chk("p4_busy", p4_bz, e.bz);
      chk("p4_done", p4_dn, e.dn);
      chk("p4_count_value", p4_cv, e.cv);
`ifdef DELAY_TIMER_OVERRUN_EN
      chk("p4_overrun", p4_ov, e.ov);
`endif
      dut_pc[1] += int'(p4_po);
      exp_pc[1] += int'(e.po);
    end
  end

  task automatic cyc_in(bit t, bit a, int m, int d, int l, bit c);
    trigger     = t;
    abort       = a;
    mode        = 2'(m);
    delay_load  = CNT_W'(d);
    pulse_len   = PW_W'(l);
    overrun_clr = c;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) cyc_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // one-shot D=5 L=3
    cyc_in(1, 0, 0, 5, 3, 0);
    idle(30);
    // one-shot D=0 L=0
    cyc_in(1, 0, 0, 0, 0, 0);
    idle(10);
    // retriggerable D=10, retrigger four edges later
    cyc_in(1, 0, 1, 10, 2, 0);
    idle(3);
    cyc_in(1, 0, 1, 10, 2, 0);
    idle(60);
    // periodic D=3 L=2, abort at k+12
    cyc_in(1, 0, 2, 3, 2, 0);
    idle(11);
    cyc_in(0, 1, 0, 0, 0, 0);
    idle(10);
    // trigger held high: back-to-back one-shots
    repeat (20) cyc_in(1, 0, 3, 1, 2, 0);
    idle(20);
    // D=2 L=1, then async reset in the middle of the delay
    cyc_in(1, 0, 0, 2, 1, 0);
    idle(16);
    cyc_in(1, 0, 0, 6, 1, 0);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_p1_busy", p1_bz, 0);
    chk("async_rst_p1_pulse_out", p1_po, 0);
    chk("async_rst_p1_count", p1_cv, 0);
    chk("async_rst_p4_busy", p4_bz, 0);
    chk("async_rst_p4_done", p4_dn, 0);
    chk("async_rst_p4_count", p4_cv, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    // dropped triggers, clear, and set-over-clear while busy
    cyc_in(1, 0, 0, 8, 2, 0);
    idle(2);
    cyc_in(1, 0, 0, 3, 1, 0);
    idle(2);
    cyc_in(0, 0, 0, 0, 0, 1);
    idle(1);
    cyc_in(1, 0, 0, 3, 1, 1);
    idle(45);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc_in(($urandom_range(7) == 0), ($urandom_range(63) == 0),
             int'($urandom_range(3)), int'($urandom_range(12)),
             int'($urandom_range(5)), ($urandom_range(15) == 0));
    end
    idle(80);

    chk("p1_pulse_cycles", dut_pc[0], exp_pc[0]);
    chk("p4_pulse_cycles", dut_pc[1], exp_pc[1]);
    chk("p1_pulses_present", (exp_pc[0] > 50), 1);
    chk("p4_pulses_present", (exp_pc[1] > 20), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
